pzcorebus_simple_responder: RTL

- Slave-side endpoint for a memory-profile pzcorebus port; the responder end of the request and response channels.
- Accepts one command at a time and consumes write-data bursts. Counts beats against the burst length and flags mismatches.
- Returns write responses for non-posted writes, and deterministic read data for reads.
- Used as a bench sink, and as a default slave behind address decoders for unmapped regions.

---
 rtl/pzcorebus_pkg.sv | 23 ++
 rtl/pzcorebus_simple_responder_if.sv | 48 ++++
 rtl/pzcorebus_simple_responder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pzcorebus_pkg.sv
// pzcorebus_pkg: command and response encodings shared by pzcorebus endpoints.
//   pzcorebus_command_type  - request command codes driven on mcmd
//   pzcorebus_response_type - response codes returned on sresp
package pzcorebus_pkg;

   typedef enum logic [3:0] {
      PZCOREBUS_NULL_COMMAND       = 4'b0000,
      PZCOREBUS_MESSAGE            = 4'b0001,
      PZCOREBUS_READ               = 4'b0010,
      PZCOREBUS_WRITE              = 4'b0011,
      PZCOREBUS_MESSAGE_NON_POSTED = 4'b0101,
      PZCOREBUS_WRITE_NON_POSTED   = 4'b0111,
      PZCOREBUS_ATOMIC             = 4'b1011,
      PZCOREBUS_ATOMIC_NON_POSTED  = 4'b1111
   } pzcorebus_command_type;

   typedef enum logic [1:0] {
      PZCOREBUS_NULL_RESPONSE      = 2'b00,
      PZCOREBUS_RESPONSE           = 2'b01,
      PZCOREBUS_RESPONSE_WITH_DATA = 2'b11
   } pzcorebus_response_type;

endpackage

// File: rtl/pzcorebus_simple_responder_if.sv
// pzcorebus_simple_responder_if: memory-profile pzcorebus port bundle.
//   request channel  : mcmd_valid/scmd_accept, mcmd, mid, maddr, mlength
//   write-data       : mdata_valid/sdata_accept, mdata, mdata_byteen, mdata_last
//   response channel : sresp_valid/mresp_accept, sresp, sid, serror, sdata, sresp_last
//   modports: master (requester side), slave (responder side)
interface pzcorebus_simple_responder_if #(
   parameter int ID_WIDTH     = 8,
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 64,
   parameter int LENGTH_WIDTH = 4
);

   logic                                   mcmd_valid;
   logic                                   scmd_accept;
   pzcorebus_pkg::pzcorebus_command_type   mcmd;
   logic [ID_WIDTH-1:0]                    mid;
   logic [ADDR_WIDTH-1:0]                  maddr;
   logic [LENGTH_WIDTH-1:0]                mlength;
   logic                                   mdata_valid;
   logic                                   sdata_accept;
   logic [DATA_WIDTH-1:0]                  mdata;
   logic [DATA_WIDTH/8-1:0]                mdata_byteen;
   logic                                   mdata_last;
   logic                                   sresp_valid;
   logic                                   mresp_accept;
   pzcorebus_pkg::pzcorebus_response_type  sresp;
   logic [ID_WIDTH-1:0]                    sid;
   logic                                   serror;
   logic [DATA_WIDTH-1:0]                  sdata;
   logic                                   sresp_last;

   modport master (
      output mcmd_valid, mcmd, mid, maddr, mlength,
      output mdata_valid, mdata, mdata_byteen, mdata_last,
      output mresp_accept,
      input  scmd_accept, sdata_accept,
      input  sresp_valid, sresp, sid, serror, sdata, sresp_last
   );

   modport slave (
      input  mcmd_valid, mcmd, mid, maddr, mlength,
      input  mdata_valid, mdata, mdata_byteen, mdata_last,
      input  mresp_accept,
      output scmd_accept, sdata_accept,
      output sresp_valid, sresp, sid, serror, sdata, sresp_last
   );

endinterface

// File: rtl/pzcorebus_simple_responder.sv
// pzcorebus_simple_responder: slave endpoint for a memory-profile pzcorebus port.
// Accepts one command at a time, consumes write bursts (checking beat count
// against mlength), answers non-posted writes with a single RESPONSE and reads
// with (maddr + beat) replicated across the data word.
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   bus             - pzcorebus slave modport (command, write data, response)
//   o_burst_error   - one-cycle pulse after a write burst whose length mismatched
module pzcorebus_simple_responder
   import pzcorebus_pkg::*;
#(
   parameter int ID_WIDTH       = 8,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 64,
   parameter int LENGTH_WIDTH   = 4,
   parameter int RESPONSE_DELAY = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   pzcorebus_simple_responder_if.slave  bus,
   output logic                         o_burst_error
);

   localparam int CW    = LENGTH_WIDTH + 1;
   localparam int WORDS = DATA_WIDTH / 32;

   typedef enum logic [1:0] {
      IDLE,
      WRITE_DATA,
      WAIT,
      RESPOND
   } state_t;

   state_t         state;
   logic           is_read;
   logic           non_posted;
   logic [31:0]    addr;
   logic [CW-1:0]  beats;
   logic [CW-1:0]  beat_count;
   logic           sticky_err;
   logic [7:0]     delay;

   logic [CW-1:0]  count_inc;
   logic           beat_err;
   logic [31:0]    next_word;
   logic           data_unused;

   assign bus.scmd_accept  = i_rst_n && (state == IDLE);
   assign bus.sdata_accept = i_rst_n && (state == WRITE_DATA);

   // write payload is intentionally discarded
   assign data_unused = ^{bus.mdata, bus.mdata_byteen};

   assign count_inc = beat_count + CW'(1);
   assign next_word = addr + 32'(count_inc);

   always_comb begin
      beat_err = bus.mdata_last ? (count_inc != beats) : (count_inc == beats);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state           <= IDLE;
         is_read         <= 1'b0;
         non_posted      <= 1'b0;
         addr            <= '0;
         beats           <= '0;
         beat_count      <= '0;
         sticky_err      <= 1'b0;
         delay           <= '0;
         bus.sresp_valid <= 1'b0;
         bus.sresp       <= PZCOREBUS_NULL_RESPONSE;
         bus.sid         <= '0;
         bus.serror      <= 1'b0;
         bus.sdata       <= '0;
         bus.sresp_last  <= 1'b0;
         o_burst_error   <= 1'b0;
      end else begin
         o_burst_error <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.mcmd_valid) begin
                  bus.sid    <= bus.mid;
                  addr       <= 32'(bus.maddr);
                  // mlength==0 encodes 2**LENGTH_WIDTH beats via the extra MSB
                  beats      <= {bus.mlength == '0, bus.mlength};
                  beat_count <= '0;
                  sticky_err <= 1'b0;
                  delay      <= 8'(RESPONSE_DELAY);
                  case (bus.mcmd)
                     PZCOREBUS_READ: begin
                        is_read <= 1'b1;
                        state   <= WAIT;
                     end
                     PZCOREBUS_WRITE: begin
                        is_read    <= 1'b0;
                        non_posted <= 1'b0;
                        state      <= WRITE_DATA;
                     end
                     PZCOREBUS_WRITE_NON_POSTED: begin
                        is_read    <= 1'b0;
                        non_posted <= 1'b1;
                        state      <= WRITE_DATA;
                     end
                     default: ; // unsupported commands are accepted and dropped
                  endcase
               end
            end
            WRITE_DATA: begin
               if (bus.mdata_valid) begin
                  if (beat_count != beats) begin
                     beat_count <= count_inc;
                  end
                  sticky_err <= sticky_err | beat_err;
                  if (bus.mdata_last) begin
                     o_burst_error <= sticky_err | beat_err;
                     if (non_posted) begin
                        delay <= 8'(RESPONSE_DELAY);
                        state <= WAIT;
                     end else begin
                        state <= IDLE;
                     end
                  end
               end
            end
            WAIT: begin
               if (delay == '0) begin
                  state           <= RESPOND;
                  bus.sresp_valid <= 1'b1;
                  if (is_read) begin
                     bus.sresp      <= PZCOREBUS_RESPONSE_WITH_DATA;
                     bus.serror     <= 1'b0;
                     bus.sdata      <= {WORDS{addr}};
                     bus.sresp_last <= (beats == CW'(1));
                     beat_count     <= '0;
                  end else begin
                     bus.sresp      <= PZCOREBUS_RESPONSE;
                     bus.serror     <= sticky_err;
                     bus.sdata      <= '0;
                     bus.sresp_last <= 1'b1;
                  end
               end else begin
                  delay <= delay - 8'd1;
               end
            end
            RESPOND: begin
               if (bus.mresp_accept) begin
                  if (bus.sresp_last) begin
                     state           <= IDLE;
                     bus.sresp_valid <= 1'b0;
                     bus.sresp_last  <= 1'b0;
                  end else begin
                     beat_count     <= count_inc;
                     bus.sdata      <= {WORDS{next_word}};
                     bus.sresp_last <= ((count_inc + CW'(1)) == beats);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
